// File: rtl/l1a_bxn_seq.sv
// Queues the bunch-crossing number of every accepted L1A into an external FIFO
// and reads the entries back out to DAQ in write order through a valid/ack handshake.
module l1a_bxn_seq #(
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             l1a,
    input  logic [11:0]      bxn,
    input  logic             flush,
    input  logic             rd_en,
    output logic [11:0]      fifo_din,
    output logic             fifo_wen,
    output logic             fifo_ren,
    output logic             fifo_reset,
    input  logic [11:0]      fifo_dout,
    output logic [11:0]      rd_bxn,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic [8:0]       occupancy,
    output logic             ovf,
    output logic [OVF_W-1:0] lost_cnt
);

    typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

    localparam logic [8:0] OCC_MAX = 9'd255;

    state_t state, state_nxt;
    logic   clr;
    logic   pop_go;
    logic   full;
    logic   accept;
    logic   drop;

    assign clr        = reset | flush;
    assign fifo_reset = clr;

    // A full queue can still take a trigger when a pop is decided on the same edge.
    always_comb begin
        pop_go = (state == IDLE) && rd_en && (occupancy != 9'd0);
        full   = (occupancy == OCC_MAX);
        accept = l1a && (!full || pop_go);
        drop   = l1a && !accept;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pop_go) state_nxt = POP;
            POP:  state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (rd_ack) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            fifo_wen  <= 1'b0;
            fifo_ren  <= 1'b0;
            fifo_din  <= 12'd0;
            rd_bxn    <= 12'd0;
            rd_valid  <= 1'b0;
            occupancy <= 9'd0;
        end else begin
            state    <= state_nxt;
            fifo_wen <= accept;
            fifo_ren <= pop_go;
            rd_valid <= (state_nxt == SEND);
            if (accept)
                fifo_din <= bxn;
            // fifo_dout is valid in LOAD, one cycle after the read strobe
            if (state == LOAD)
                rd_bxn <= fifo_dout;
            case ({accept, pop_go})
                2'b10:   occupancy <= occupancy + 9'd1;
                2'b01:   occupancy <= occupancy - 9'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Loss accounting survives flush; only a true reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf      <= 1'b0;
            lost_cnt <= '0;
        end else if (!flush && drop) begin
            ovf <= 1'b1;
            if (lost_cnt != '1)
                lost_cnt <= lost_cnt + OVF_W'(1);
        end
    end

endmodule

// File: tb/tb_l1a_bxn_seq.sv
// Directed bench for l1a_bxn_seq: stimulus pushes expected BXNs into a queue,
// a monitor pops and compares on every DAQ handshake.
module tb_l1a_bxn_seq;

    logic        clk = 1'b0;
    logic        reset, l1a, flush, rd_en, rd_ack;
    logic [11:0] bxn;

    logic [11:0] fifo_din_a, fifo_dout_a, rd_bxn_a;
    logic        fifo_wen_a, fifo_ren_a, fifo_reset_a, rd_valid_a, ovf_a;
    logic [8:0]  occupancy_a;
    logic [7:0]  lost_cnt_a;

    logic [11:0] fifo_din_b, fifo_dout_b, rd_bxn_b;
    logic        fifo_wen_b, fifo_ren_b, fifo_reset_b, rd_valid_b, ovf_b;
    logic [8:0]  occupancy_b;
    logic [1:0]  lost_cnt_b;

    logic [11:0] fq_a[$];
    logic [11:0] fq_b[$];
    logic [11:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l1a_bxn_seq #(.OVF_W(8)) dut_a (
        .clk(clk), .reset(reset), .l1a(l1a), .bxn(bxn), .flush(flush), .rd_en(rd_en),
        .fifo_din(fifo_din_a), .fifo_wen(fifo_wen_a), .fifo_ren(fifo_ren_a),
        .fifo_reset(fifo_reset_a), .fifo_dout(fifo_dout_a), .rd_bxn(rd_bxn_a),
        .rd_valid(rd_valid_a), .rd_ack(rd_ack), .occupancy(occupancy_a),
        .ovf(ovf_a), .lost_cnt(lost_cnt_a)
    );

    l1a_bxn_seq #(.OVF_W(2)) dut_b (
        .clk(clk), .reset(reset), .l1a(l1a), .bxn(bxn), .flush(flush), .rd_en(rd_en),
        .fifo_din(fifo_din_b), .fifo_wen(fifo_wen_b), .fifo_ren(fifo_ren_b),
        .fifo_reset(fifo_reset_b), .fifo_dout(fifo_dout_b), .rd_bxn(rd_bxn_b),
        .rd_valid(rd_valid_b), .rd_ack(rd_ack), .occupancy(occupancy_b),
        .ovf(ovf_b), .lost_cnt(lost_cnt_b)
    );

    // Behavioural BXN FIFOs, read data registered one cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_reset_a) begin
            fq_a.delete();
        end else begin
            if (fifo_ren_a && fq_a.size() > 0) fifo_dout_a <= fq_a.pop_front();
            if (fifo_wen_a) fq_a.push_back(fifo_din_a);
        end
    end

    always @(posedge clk) begin
        if (fifo_reset_b) begin
            fq_b.delete();
        end else begin
            if (fifo_ren_b && fq_b.size() > 0) fifo_dout_b <= fq_b.pop_front();
            if (fifo_wen_b) fq_b.push_back(fifo_din_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must deliver the oldest expected BXN.
    always @(negedge clk) begin
        if (!reset && !flush && rd_valid_a && rd_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", {20'd0, rd_bxn_a}, 32'hFFFFFFFF);
            end else begin
                chk("rd_bxn_order", {20'd0, rd_bxn_a}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!rd_valid_a && n < bound) begin
            tick();
            n++;
        end
        chk("wait_valid", {31'd0, rd_valid_a}, 32'd1);
    endtask

    task automatic drain(input int bound, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; l1a = 1'b0; flush = 1'b0; rd_en = 1'b0; rd_ack = 1'b0; bxn = 12'd0;

        // Reset state
        #1;
        chk("fifo_reset_in_reset", {31'd0, fifo_reset_a}, 32'd1);
        repeat (3) tick();
        chk("rst_occupancy", {23'd0, occupancy_a}, 32'd0);
        chk("rst_rd_valid",  {31'd0, rd_valid_a}, 32'd0);
        chk("rst_fifo_wen",  {31'd0, fifo_wen_a}, 32'd0);
        chk("rst_fifo_ren",  {31'd0, fifo_ren_a}, 32'd0);
        chk("rst_rd_bxn",    {20'd0, rd_bxn_a}, 32'd0);
        chk("rst_fifo_din",  {20'd0, fifo_din_a}, 32'd0);
        chk("rst_ovf",       {31'd0, ovf_a}, 32'd0);
        chk("rst_lost_cnt",  {24'd0, lost_cnt_a}, 32'd0);
        reset = 1'b0;
        #1;
        chk("fifo_reset_released", {31'd0, fifo_reset_a}, 32'd0);
        tick();

        // Single trigger: l1a at N -> fifo_wen at N+1, rd_valid at N+4
        rd_en = 1'b1; rd_ack = 1'b1; bxn = 12'h123; l1a = 1'b1;
        exp_q.push_back(12'h123);
        tick();
        l1a = 1'b0;
        chk("single_fifo_wen", {31'd0, fifo_wen_a}, 32'd1);
        chk("single_fifo_din", {20'd0, fifo_din_a}, 32'h123);
        chk("single_occ_1",    {23'd0, occupancy_a}, 32'd1);
        tick();
        chk("single_fifo_ren", {31'd0, fifo_ren_a}, 32'd1);
        chk("single_wen_pulse", {31'd0, fifo_wen_a}, 32'd0);
        chk("single_occ_0",    {23'd0, occupancy_a}, 32'd0);
        tick();
        chk("single_not_yet_valid", {31'd0, rd_valid_a}, 32'd0);
        tick();
        chk("single_valid_n4", {31'd0, rd_valid_a}, 32'd1);
        chk("single_rd_bxn",   {20'd0, rd_bxn_a}, 32'h123);
        tick();
        chk("single_valid_drop", {31'd0, rd_valid_a}, 32'd0);

        // Fill to 255 with rd_en low; the 256th trigger is lost
        rd_en = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bxn = 12'(i);
            l1a = 1'b1;
            if (i < 255) exp_q.push_back(12'(i));
            tick();
        end
        l1a = 1'b0;
        chk("fill_occ",       {23'd0, occupancy_a}, 32'd255);
        chk("fill_drop_nowen", {31'd0, fifo_wen_a}, 32'd0);
        chk("fill_ovf",       {31'd0, ovf_a}, 32'd1);
        chk("fill_lost_a",    {24'd0, lost_cnt_a}, 32'd1);
        chk("fill_lost_b",    {30'd0, lost_cnt_b}, 32'd1);

        // Five more drops: 8-bit counter reaches 6, 2-bit counter saturates at 3
        bxn = 12'h800; l1a = 1'b1;
        repeat (5) tick();
        l1a = 1'b0;
        chk("sat_lost_a", {24'd0, lost_cnt_a}, 32'd6);
        chk("sat_lost_b", {30'd0, lost_cnt_b}, 32'd3);
        chk("sat_occ",    {23'd0, occupancy_a}, 32'd255);

        // Trigger on the same edge as a pop decision while full; 0xFFF is ordinary data
        rd_en = 1'b1; l1a = 1'b1; bxn = 12'hFFF;
        exp_q.push_back(12'hFFF);
        tick();
        l1a = 1'b0;
        chk("simul_occ",      {23'd0, occupancy_a}, 32'd255);
        chk("simul_fifo_wen", {31'd0, fifo_wen_a}, 32'd1);
        chk("simul_fifo_din", {20'd0, fifo_din_a}, 32'hFFF);
        chk("simul_fifo_ren", {31'd0, fifo_ren_a}, 32'd1);
        chk("simul_lost_a",   {24'd0, lost_cnt_a}, 32'd6);
        chk("simul_ovf",      {31'd0, ovf_a}, 32'd1);

        // 256 entries at one per 4 cycles: last handshake 1023 edges after the first pop
        drain(1500, n);
        chk("drain_cycles", n, 32'd1023);
        chk("drain_occ",    {23'd0, occupancy_a}, 32'd0);

        // Backpressure
        tick();
        rd_ack = 1'b0;
        bxn = 12'hA5A; l1a = 1'b1; exp_q.push_back(12'hA5A);
        tick();
        bxn = 12'h5A5; exp_q.push_back(12'h5A5);
        tick();
        l1a = 1'b0;
        wait_valid(10);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid_held", {31'd0, rd_valid_a}, 32'd1);
            chk("bp_bxn_stable", {20'd0, rd_bxn_a}, 32'hA5A);
            tick();
        end
        chk("bp_occ", {23'd0, occupancy_a}, 32'd1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("bp_after_ack_valid", {31'd0, rd_valid_a}, 32'd0);
        chk("bp_after_ack_idle",  {31'd0, fifo_ren_a}, 32'd0);
        tick();
        chk("bp_next_pop", {31'd0, fifo_ren_a}, 32'd1);
        chk("bp_next_occ", {23'd0, occupancy_a}, 32'd0);
        rd_ack = 1'b1;
        drain(20, n);
        tick();

        // Flush mid-SEND with a coincident trigger that must vanish
        rd_en = 1'b0; rd_ack = 1'b0;
        bxn = 12'h111; l1a = 1'b1; exp_q.push_back(12'h111); tick();
        bxn = 12'h222; exp_q.push_back(12'h222); tick();
        bxn = 12'h333; exp_q.push_back(12'h333); tick();
        l1a = 1'b0;
        chk("flush_pre_occ", {23'd0, occupancy_a}, 32'd3);
        rd_en = 1'b1;
        wait_valid(10);
        chk("flush_pre_bxn", {20'd0, rd_bxn_a}, 32'h111);
        flush = 1'b1; l1a = 1'b1; bxn = 12'h777;
        exp_q.delete();
        #1;
        chk("flush_fifo_reset", {31'd0, fifo_reset_a}, 32'd1);
        tick();
        flush = 1'b0; l1a = 1'b0;
        chk("flush_rd_valid", {31'd0, rd_valid_a}, 32'd0);
        chk("flush_occ",      {23'd0, occupancy_a}, 32'd0);
        chk("flush_no_write", {31'd0, fifo_wen_a}, 32'd0);
        chk("flush_lost_a",   {24'd0, lost_cnt_a}, 32'd6);
        chk("flush_lost_b",   {30'd0, lost_cnt_b}, 32'd3);
        chk("flush_ovf",      {31'd0, ovf_a}, 32'd1);
        tick();
        chk("flush_idle_ren",   {31'd0, fifo_ren_a}, 32'd0);
        chk("flush_idle_valid", {31'd0, rd_valid_a}, 32'd0);
        chk("flush_released",   {31'd0, fifo_reset_a}, 32'd0);
        bxn = 12'h0FF; l1a = 1'b1; rd_ack = 1'b1; exp_q.push_back(12'h0FF);
        tick();
        l1a = 1'b0;
        drain(20, n);
        tick();

        // Reset arriving in the POP cycle
        bxn = 12'h456; l1a = 1'b1; exp_q.push_back(12'h456);
        tick();
        l1a = 1'b0;
        tick();
        chk("rpop_in_pop", {31'd0, fifo_ren_a}, 32'd1);
        reset = 1'b1; l1a = 1'b1;
        exp_q.delete();
        #1;
        chk("rpop_fifo_reset", {31'd0, fifo_reset_a}, 32'd1);
        tick();
        reset = 1'b0; l1a = 1'b0;
        chk("rpop_ren",      {31'd0, fifo_ren_a}, 32'd0);
        chk("rpop_valid",    {31'd0, rd_valid_a}, 32'd0);
        chk("rpop_occ",      {23'd0, occupancy_a}, 32'd0);
        chk("rpop_ovf",      {31'd0, ovf_a}, 32'd0);
        chk("rpop_lost_a",   {24'd0, lost_cnt_a}, 32'd0);
        chk("rpop_lost_b",   {30'd0, lost_cnt_b}, 32'd0);
        chk("rpop_wen",      {31'd0, fifo_wen_a}, 32'd0);
        chk("rpop_rd_bxn",   {20'd0, rd_bxn_a}, 32'd0);
        chk("rpop_fifo_din", {20'd0, fifo_din_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rpop_stays_idle", {31'd0, rd_valid_a}, 32'd0);
        end

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
